// File: rtl/vga_fb_ctrl.sv
// rtl/vga_fb_ctrl.sv - VGA framebuffer controller: four-phase CPU bus port plus sync/scanout engine
`ifndef VGA_WRITE_PIN
`define VGA_WRITE_PIN 0
`endif
`ifndef VGA_READ_PIN
`define VGA_READ_PIN 1
`endif
`ifndef VGA_ACK
`define VGA_ACK 0
`endif

module vga_fb_ctrl #(
    parameter int   word_width  = 32,
    parameter int   pixel_bits  = 8,
    parameter int   fb_w        = 160,
    parameter int   fb_h        = 120,
    parameter int   scale_shift = 2,
    parameter int   clk_div     = 4,
    parameter int   h_active    = 640,
    parameter int   h_fp        = 16,
    parameter int   h_sync      = 96,
    parameter int   h_bp        = 48,
    parameter int   v_active    = 480,
    parameter int   v_fp        = 10,
    parameter int   v_sync      = 2,
    parameter int   v_bp        = 33,
    parameter logic sync_pol    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] vga_ctrl,
    output logic [word_width-1:0] vga_stat,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_in,
    output logic [word_width-1:0] data_out,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [pixel_bits-1:0] rgb
);

    localparam int FB_SIZE = fb_w * fb_h;
    // One extra bit so FB_SIZE itself is representable for range checks
    localparam int AW      = $clog2(FB_SIZE + 1);
    localparam int H_TOTAL = h_active + h_fp + h_sync + h_bp;
    localparam int V_TOTAL = v_active + v_fp + v_sync + v_bp;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DW      = $clog2(clk_div);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK_HOLD} bus_state_t;

    logic [pixel_bits-1:0] mem [FB_SIZE];

    bus_state_t            state_q, state_d;
    logic [word_width-1:0] addr_q, addr_d;
    logic [pixel_bits-1:0] wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic                  ack_q, ack_d;
    logic [word_width-1:0] data_out_q, data_out_d;

    logic [DW-1:0]         div_q, div_d;
    logic [HW-1:0]         h_cnt_q, h_cnt_d;
    logic [VW-1:0]         v_cnt_q, v_cnt_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  de_q, de_d;
    logic [pixel_bits-1:0] rgb_q, rgb_d;

    logic                  req_wr, req_rd;
    logic                  bus_in_range, mem_we;
    logic [AW-1:0]         bus_idx, pix_addr;
    logic                  tick, active, h_in_sync, v_in_sync, pix_ok;
    logic                  unused_ok;

    assign req_wr       = vga_ctrl[`VGA_WRITE_PIN];
    assign req_rd       = vga_ctrl[`VGA_READ_PIN];
    assign bus_in_range = addr_q < word_width'(FB_SIZE);
    assign bus_idx      = addr_q[AW-1:0];
    assign mem_we       = (state_q == S_ACCESS) && is_wr_q && bus_in_range;
    assign unused_ok    = ^{vga_ctrl, data_in};

    // Bus handshake: latch request, access memory for one cycle, hold ACK until pins drop
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        ack_d      = ack_q;
        data_out_d = data_out_q;
        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                if (req_wr || req_rd) begin
                    addr_d  = addr;
                    wdata_d = data_in[pixel_bits-1:0];
                    is_wr_d = req_wr;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!is_wr_q) begin
                    data_out_d = bus_in_range ? word_width'(mem[bus_idx]) : '0;
                end
                state_d = S_ACK_HOLD;
            end
            S_ACK_HOLD: begin
                // ACK rises on the first edge spent here and falls on the edge that sees both pins low
                if (!req_wr && !req_rd) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel divider, raster counters and the one-tick-delayed scanout outputs
    always_comb begin
        tick      = div_q == DW'(clk_div - 1);
        div_d     = tick ? '0 : div_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        de_d      = de_q;
        rgb_d     = rgb_q;
        active    = (h_cnt_q < HW'(h_active)) && (v_cnt_q < VW'(v_active));
        h_in_sync = (h_cnt_q >= HW'(h_active + h_fp)) && (h_cnt_q < HW'(h_active + h_fp + h_sync));
        v_in_sync = (v_cnt_q >= VW'(v_active + v_fp)) && (v_cnt_q < VW'(v_active + v_fp + v_sync));
        pix_addr  = AW'(v_cnt_q >> scale_shift) * AW'(fb_w) + AW'(h_cnt_q >> scale_shift);
        pix_ok    = active && (pix_addr < AW'(FB_SIZE));
        if (tick) begin
            if (h_cnt_q == HW'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            hsync_d = h_in_sync ? sync_pol : ~sync_pol;
            vsync_d = v_in_sync ? sync_pol : ~sync_pol;
            de_d    = active;
            rgb_d   = pix_ok ? mem[pix_addr] : '0;
        end
    end

    // State registers for the bus side and the scanout side
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            ack_q      <= 1'b0;
            data_out_q <= '0;
            div_q      <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            hsync_q    <= ~sync_pol;
            vsync_q    <= ~sync_pol;
            de_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            ack_q      <= ack_d;
            data_out_q <= data_out_d;
            div_q      <= div_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            rgb_q      <= rgb_d;
        end
    end

    // Framebuffer write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus_idx] <= wdata_q;
        end
    end

    // Status word carries only the ACK bit
    always_comb begin
        vga_stat = '0;
        vga_stat[`VGA_ACK] = ack_q;
    end

    assign data_out = data_out_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign de       = de_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb/tb_vga_fb_ctrl.sv - randomized self-checking bench for vga_fb_ctrl with a raster reference model
`ifndef VGA_WRITE_PIN
`define VGA_WRITE_PIN 0
`endif
`ifndef VGA_READ_PIN
`define VGA_READ_PIN 1
`endif
`ifndef VGA_ACK
`define VGA_ACK 0
`endif

module tb_vga_fb_ctrl;

    localparam int FBW = 160, FBH = 120, FB = FBW * FBH;
    localparam int DIV = 4;
    localparam int HA = 32, HFP = 4, HS = 6, HBP = 4, HT = HA + HFP + HS + HBP;
    localparam int VA = 24, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int FRAME_CLKS = HT * VT * DIV;
    localparam int EXP_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] vga_ctrl = '0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    wire  [31:0] vga_stat;
    wire  [31:0] data_out;
    wire         hsync, vsync, de;
    wire  [7:0]  rgb;

    int n_cmp = 0;
    int n_fail = 0;
    int ecount = 0;
    logic [7:0] ref_fb [FB];
    bit         written [FB];

    vga_fb_ctrl #(
        .word_width(32), .pixel_bits(8), .fb_w(FBW), .fb_h(FBH), .scale_shift(2), .clk_div(DIV),
        .h_active(HA), .h_fp(HFP), .h_sync(HS), .h_bp(HBP),
        .v_active(VA), .v_fp(VFP), .v_sync(VS), .v_bp(VBP), .sync_pol(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .vga_ctrl(vga_ctrl), .vga_stat(vga_stat),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Clock edges elapsed since the last edge that saw reset
    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {hsync, vsync, de, rgb} after e edges: one tick per DIV edges, outputs show the previous tick's position
    function automatic logic [10:0] exp_out(input int e);
        int t, p, h, v;
        logic hs, vs, d;
        logic [7:0] c;
        t = e / DIV;
        if (t == 0) return {1'b1, 1'b1, 1'b0, 8'h00};
        p  = t - 1;
        h  = p % HT;
        v  = (p / HT) % VT;
        d  = (h < HA) && (v < VA);
        hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
        vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
        c  = d ? ref_fb[(v >> 2) * FBW + (h >> 2)] : 8'h00;
        return {hs, vs, d, c};
    endfunction

    // Four-phase request: raise pins, wait for ACK (bounded), drop pins, sample status one edge later
    task automatic bus_op(input bit w, input bit r, input int a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output logic [31:0] stat_after);
        vga_ctrl = '0;
        vga_ctrl[`VGA_WRITE_PIN] = w;
        vga_ctrl[`VGA_READ_PIN]  = r;
        addr    = a;
        data_in = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (vga_stat[`VGA_ACK] !== 1'b1 && lat < 12);
        rd = data_out;
        vga_ctrl = '0;
        @(posedge clk); #1;
        stat_after = vga_stat;
        if (w && a >= 0 && a < FB) begin
            ref_fb[a]  = d[7:0];
            written[a] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({vga_stat, data_out} !== 64'h0) begin
            n_fail++; $display("FAIL reset_bus: got stat=%h data_out=%h expected 0/0", vga_stat, data_out);
        end
        n_cmp++;
        if ({hsync, vsync, de, rgb} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL reset_video: got hs=%b vs=%b de=%b rgb=%h expected 1 1 0 00", hsync, vsync, de, rgb);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, st;
        int lat;
        bus_op(1, 0, 5, 32'h1234_56A7, rd, lat, st);
        n_cmp++;
        if (lat !== EXP_LAT) begin n_fail++; $display("FAIL wr_ack_latency: got %0d expected %0d", lat, EXP_LAT); end
        n_cmp++;
        if (st !== 32'h0) begin n_fail++; $display("FAIL wr_ack_fall: got %h expected 0", st); end
        bus_op(0, 1, 5, 32'h0, rd, lat, st);
        n_cmp++;
        if (rd !== 32'h0000_00A7) begin n_fail++; $display("FAIL rd_addr5: got %h expected 000000a7", rd); end
        n_cmp++;
        if (lat !== EXP_LAT) begin n_fail++; $display("FAIL rd_ack_latency: got %0d expected %0d", lat, EXP_LAT); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, st, hold;
        int lat;
        bus_op(1, 0, FB - 1, 32'h0000_005A, rd, lat, st);
        bus_op(1, 0, FB, 32'hFFFF_FFFF, rd, lat, st);
        n_cmp++;
        if (lat !== EXP_LAT || st !== 32'h0) begin
            n_fail++; $display("FAIL oor_wr_ack: got lat=%0d stat=%h expected %0d/0", lat, st, EXP_LAT);
        end
        bus_op(0, 1, FB, 32'h0, rd, lat, st);
        n_cmp++;
        if (rd !== 32'h0 || lat !== EXP_LAT) begin
            n_fail++; $display("FAIL oor_rd: got data=%h lat=%0d expected 0/%0d", rd, lat, EXP_LAT);
        end
        bus_op(0, 1, FB - 1, 32'h0, rd, lat, st);
        n_cmp++;
        if (rd !== 32'h0000_005A) begin n_fail++; $display("FAIL last_pixel_kept: got %h expected 0000005a", rd); end
        bus_op(1, 0, FB, 32'h0000_0011, hold, lat, st);
        n_cmp++;
        if (data_out !== 32'h0000_005A) begin n_fail++; $display("FAIL data_out_held_on_write: got %h expected 0000005a", data_out); end
    endtask

    task automatic test_both_pins();
        logic [31:0] rd, st;
        int lat;
        bus_op(1, 1, 7, 32'h0000_003C, rd, lat, st);
        bus_op(0, 1, 7, 32'h0, rd, lat, st);
        n_cmp++;
        if (rd !== 32'h0000_003C) begin n_fail++; $display("FAIL both_pins_write: got %h expected 0000003c", rd); end
    endtask

    task automatic test_random_bus();
        logic [31:0] rd, st, d, exp;
        int lat, a, op;
        int wq[$];
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            d  = $urandom;
            if (op == 1 && wq.size() > 0 && $urandom_range(0, 2) != 0)
                a = wq[$urandom_range(0, wq.size() - 1)];
            else if ($urandom_range(0, 3) == 0)
                a = FB + $urandom_range(0, 200);
            else
                a = $urandom_range(0, FB - 1);
            bus_op(op != 1, op != 0, a, d, rd, lat, st);
            if (op != 1 && a < FB) wq.push_back(a);
            n_cmp++;
            if (lat !== EXP_LAT || st !== 32'h0) begin
                n_fail++; $display("FAIL rand_handshake[%0d]: got lat=%0d stat=%h expected %0d/0", i, lat, st, EXP_LAT);
            end
            if (op == 1 && (a >= FB || written[a])) begin
                exp = (a >= FB) ? 32'h0 : {24'h0, ref_fb[a]};
                n_cmp++;
                if (rd !== exp) begin n_fail++; $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", i, a, rd, exp); end
            end
        end
    endtask

    task automatic test_reset_in_ack_hold();
        int lat;
        vga_ctrl = '0;
        vga_ctrl[`VGA_READ_PIN] = 1'b1;
        addr = 5;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (vga_stat[`VGA_ACK] !== 1'b1 && lat < 12);
        n_cmp++;
        if (data_out !== {24'h0, ref_fb[5]}) begin n_fail++; $display("FAIL pre_reset_read: got %h expected %h", data_out, ref_fb[5]); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({vga_stat, data_out} !== 64'h0) begin
            n_fail++; $display("FAIL ackhold_reset_bus: got stat=%h data_out=%h expected 0/0", vga_stat, data_out);
        end
        n_cmp++;
        if ({hsync, vsync, de} !== 3'b110) begin
            n_fail++; $display("FAIL ackhold_reset_sync: got %b expected 110", {hsync, vsync, de});
        end
        rst = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (vga_stat[`VGA_ACK] !== 1'b1 && lat < 12);
        n_cmp++;
        if (lat !== EXP_LAT) begin n_fail++; $display("FAIL ack_after_reset: got %0d expected %0d", lat, EXP_LAT); end
        n_cmp++;
        if (data_out !== {24'h0, ref_fb[5]}) begin n_fail++; $display("FAIL post_reset_read: got %h expected %h", data_out, ref_fb[5]); end
        vga_ctrl = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_scanout_frame();
        bit done = 0;
        int first_hs = -1;
        int bus_bad = 0;
        logic [31:0] rd, st;
        int lat;
        logic [10:0] exp, got;
        for (int y = 0; y < VA / 4; y++)
            for (int x = 0; x < HA / 4; x++)
                bus_op(1, 0, y * FBW + x, 32'($urandom_range(0, 255)), rd, lat, st);
        bus_op(1, 0, 0,   32'h11, rd, lat, st);
        bus_op(1, 0, 1,   32'h22, rd, lat, st);
        bus_op(1, 0, FBW, 32'h33, rd, lat, st);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fork
            begin
                for (int c = 0; c < FRAME_CLKS + 2 * HT * DIV; c++) begin
                    @(negedge clk);
                    exp = exp_out(ecount);
                    got = {hsync, vsync, de, rgb};
                    if (first_hs < 0 && hsync === 1'b0) first_hs = ecount;
                    n_cmp++;
                    if (got !== exp) begin
                        n_fail++; $display("FAIL raster edge %0d: got %h expected %h", ecount, got, exp);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    bus_op(1, 0, $urandom_range((VA / 4) * FBW, FB - 1), $urandom, rd, lat, st);
                    if (lat !== EXP_LAT) bus_bad++;
                end
            end
        join
        n_cmp++;
        if (first_hs !== (HA + HFP + 1) * DIV) begin
            n_fail++; $display("FAIL first_hsync_edge: got %0d expected %0d", first_hs, (HA + HFP + 1) * DIV);
        end
        n_cmp++;
        if (bus_bad !== 0) begin n_fail++; $display("FAIL bus_during_scan: got %0d slow acks expected 0", bus_bad); end
    endtask

    task automatic test_timing_counts();
        int de_n = 0, hs_n = 0, vs_n = 0, t0 = -1, t1 = -1, run = 0, c = 0;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            @(negedge clk);
            de_n += (de === 1'b1);
            hs_n += (hsync === 1'b0);
            vs_n += (vsync === 1'b0);
        end
        n_cmp++;
        if (de_n !== HA * VA * DIV) begin n_fail++; $display("FAIL de_per_frame: got %0d expected %0d", de_n, HA * VA * DIV); end
        n_cmp++;
        if (hs_n !== HS * VT * DIV) begin n_fail++; $display("FAIL hsync_per_frame: got %0d expected %0d", hs_n, HS * VT * DIV); end
        n_cmp++;
        if (vs_n !== VS * HT * DIV) begin n_fail++; $display("FAIL vsync_per_frame: got %0d expected %0d", vs_n, VS * HT * DIV); end
        // Line period between successive hsync assertions, and the width of one pulse
        while (c < 3 * HT * DIV && t1 < 0) begin
            @(negedge clk);
            c++;
            if (hsync === 1'b0) begin
                run++;
                if (run == 1) begin
                    if (t0 < 0) t0 = c;
                    else        t1 = c;
                end
            end else if (t0 >= 0 && t1 < 0 && run > 0) begin
                n_cmp++;
                if (run !== HS * DIV) begin n_fail++; $display("FAIL hsync_width: got %0d expected %0d", run, HS * DIV); end
                run = 0;
            end else begin
                run = 0;
            end
        end
        n_cmp++;
        if (t1 - t0 !== HT * DIV) begin n_fail++; $display("FAIL line_period: got %0d expected %0d", t1 - t0, HT * DIV); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_both_pins();
        test_random_bus();
        test_reset_in_ack_hold();
        test_scanout_frame();
        test_timing_counts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
